// File: rtl/servo_pkg.sv
// Shared types and the angle-to-pulse mapping for the panel servo driver.
package servo_pkg;

  typedef logic [7:0] angle_t;

  localparam int ANGLE_MAX  = 180;
  localparam int HOME_ANGLE = 90;

  // Integer arithmetic, so the product has plenty of headroom; division truncates.
  function automatic int angle_to_pulse(angle_t angle, int min_ticks, int max_ticks,
                                        int max_angle);
    int a;
    a = int'({24'd0, angle});
    return min_ticks + (a * (max_ticks - min_ticks)) / max_angle;
  endfunction

endpackage

// File: rtl/panel_servo_driver_if.sv
// Command handshake from the tracking controller: two target angles under valid/ready.
interface panel_servo_driver_if;
  import servo_pkg::*;

  logic   cmd_valid;
  logic   cmd_ready;
  angle_t cmd_base;
  angle_t cmd_arm;

  modport master (output cmd_valid, output cmd_base, output cmd_arm, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_base, input cmd_arm, output cmd_ready);

endinterface

// File: rtl/servo_axis.sv
// One servo axis: target register, per-frame slew toward it, latched pulse width and PWM.
module servo_axis
  import servo_pkg::*;
#(
  parameter int FRAME_TICKS     = 20000,
  parameter int MIN_PULSE_TICKS = 1000,
  parameter int MAX_PULSE_TICKS = 2000,
  parameter int MAX_ANGLE       = ANGLE_MAX,
  parameter int STEP            = 2,
  parameter int HOME_ANGLE      = servo_pkg::HOME_ANGLE,
  parameter int CNT_W           = $clog2(FRAME_TICKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_start,
  input  logic [CNT_W-1:0] frame_cnt,
  input  logic             load,
  input  angle_t           cmd_angle,
  output angle_t           pos,
  output logic             moving,
  output logic             pwm
);

  localparam logic signed [8:0] STEP_S     = 9'(STEP);
  localparam logic [CNT_W-1:0]  HOME_PULSE = CNT_W'(angle_to_pulse(angle_t'(HOME_ANGLE),
                                               MIN_PULSE_TICKS, MAX_PULSE_TICKS, MAX_ANGLE));

  angle_t            tgt;
  angle_t            tgt_clamped;
  angle_t            pos_next;
  logic signed [8:0] d;
  logic [CNT_W-1:0]  pulse;

  assign tgt_clamped = (cmd_angle > angle_t'(MAX_ANGLE)) ? angle_t'(MAX_ANGLE) : cmd_angle;
  assign moving      = (pos != tgt);

  always_comb begin
    d        = $signed({1'b0, tgt}) - $signed({1'b0, pos});
    pos_next = tgt;
    if (d > STEP_S)
      pos_next = pos + angle_t'(STEP);
    else if (d < -STEP_S)
      pos_next = pos - angle_t'(STEP);
  end

  // Slew reads the target held before this edge, so a command landing on the
  // frame-start cycle waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt   <= angle_t'(HOME_ANGLE);
      pos   <= angle_t'(HOME_ANGLE);
      pulse <= HOME_PULSE;
      pwm   <= 1'b0;
    end else begin
      if (load)
        tgt <= tgt_clamped;
      if (frame_start) begin
        pos   <= pos_next;
        pulse <= CNT_W'(angle_to_pulse(pos_next, MIN_PULSE_TICKS, MAX_PULSE_TICKS, MAX_ANGLE));
      end
      pwm <= enable && (frame_cnt < pulse);
    end
  end

endmodule

// File: rtl/panel_servo_driver.sv
// Panel-side servo driver: shared frame counter, command handshake, two slewing
// servo axes and busy/arrived status.
module panel_servo_driver
  import servo_pkg::*;
#(
  parameter int FRAME_TICKS     = 20000,
  parameter int MIN_PULSE_TICKS = 1000,
  parameter int MAX_PULSE_TICKS = 2000,
  parameter int MAX_ANGLE       = ANGLE_MAX,
  parameter int STEP            = 2,
  parameter int HOME_ANGLE      = servo_pkg::HOME_ANGLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  panel_servo_driver_if.slave  cmd,
  output logic                 pwm_base,
  output logic                 pwm_arm,
  output angle_t               pos_base,
  output angle_t               pos_arm,
  output logic                 busy,
  output logic                 arrived
);

  localparam int CNT_W = $clog2(FRAME_TICKS);

  if (MAX_PULSE_TICKS >= FRAME_TICKS) begin : g_chk_frame
    $error("panel_servo_driver: MAX_PULSE_TICKS must be below FRAME_TICKS");
  end
  if (MIN_PULSE_TICKS < 1) begin : g_chk_min
    $error("panel_servo_driver: MIN_PULSE_TICKS must be at least 1");
  end
  if (MAX_ANGLE < 1 || MAX_ANGLE > 255) begin : g_chk_angle
    $error("panel_servo_driver: MAX_ANGLE must fit an 8-bit angle");
  end

  logic [CNT_W-1:0] frame_cnt;
  logic             frame_start;
  logic             ready_q;
  logic             accept;
  logic             moving_base;
  logic             moving_arm;
  logic             moving_any;

  assign frame_start   = enable && (frame_cnt == '0);
  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid && ready_q;
  assign moving_any    = moving_base || moving_arm;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      ready_q   <= 1'b0;
      busy      <= 1'b0;
      arrived   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (enable)
        frame_cnt <= (frame_cnt == CNT_W'(FRAME_TICKS - 1)) ? '0 : frame_cnt + 1'b1;
      busy    <= moving_any;
      arrived <= busy && !moving_any;
    end
  end

  servo_axis #(
    .FRAME_TICKS(FRAME_TICKS), .MIN_PULSE_TICKS(MIN_PULSE_TICKS),
    .MAX_PULSE_TICKS(MAX_PULSE_TICKS), .MAX_ANGLE(MAX_ANGLE), .STEP(STEP),
    .HOME_ANGLE(HOME_ANGLE), .CNT_W(CNT_W)
  ) u_base (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .load(accept), .cmd_angle(cmd.cmd_base),
    .pos(pos_base), .moving(moving_base), .pwm(pwm_base)
  );

  servo_axis #(
    .FRAME_TICKS(FRAME_TICKS), .MIN_PULSE_TICKS(MIN_PULSE_TICKS),
    .MAX_PULSE_TICKS(MAX_PULSE_TICKS), .MAX_ANGLE(MAX_ANGLE), .STEP(STEP),
    .HOME_ANGLE(HOME_ANGLE), .CNT_W(CNT_W)
  ) u_arm (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .load(accept), .cmd_angle(cmd.cmd_arm),
    .pos(pos_arm), .moving(moving_arm), .pwm(pwm_arm)
  );

endmodule

// File: tb/tb_panel_servo_driver.sv
// Bench for panel_servo_driver: behavioural model compared every cycle, plus
// hand-computed expectations for slew sequences, pulse totals, enable gaps and reset.
module tb_panel_servo_driver;
  import servo_pkg::*;

  localparam int FT = 400, MINP = 100, MAXP = 280, MAXA = 180, STP = 2, HOME = 90;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   enable = 1'b1;
  logic   pwm_base, pwm_arm, busy, arrived;
  angle_t pos_base, pos_arm;

  panel_servo_driver_if cif();

  panel_servo_driver #(
    .FRAME_TICKS(FT), .MIN_PULSE_TICKS(MINP), .MAX_PULSE_TICKS(MAXP),
    .MAX_ANGLE(MAXA), .STEP(STP), .HOME_ANGLE(HOME)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd(cif.slave),
    .pwm_base(pwm_base), .pwm_arm(pwm_arm), .pos_base(pos_base), .pos_arm(pos_arm),
    .busy(busy), .arrived(arrived)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int arr_seen = 0;
  bit chk_on = 1'b0;

  // Model state: what the outputs must be after each edge.
  int m_cnt = 0;
  int m_pos[2];
  int m_tgt[2];
  int m_pulse[2];
  bit m_pwm[2];
  bit m_busy = 1'b0, m_arr = 1'b0, m_ready = 1'b0;

  function automatic int to_pulse(int a);
    return MINP + (a * (MAXP - MINP)) / MAXA;
  endfunction

  task automatic model_step();
    int  cmdv[2];
    int  d;
    bit  diff, fs, acc;
    cmdv[0] = int'(cif.cmd_base);
    cmdv[1] = int'(cif.cmd_arm);
    if (rst) begin
      m_cnt = 0; m_busy = 0; m_arr = 0; m_ready = 0;
      for (int i = 0; i < 2; i++) begin
        m_pos[i] = HOME; m_tgt[i] = HOME; m_pulse[i] = to_pulse(HOME); m_pwm[i] = 0;
      end
    end else begin
      diff   = (m_pos[0] != m_tgt[0]) || (m_pos[1] != m_tgt[1]);
      m_arr  = m_busy && !diff;
      m_busy = diff;
      fs  = enable && (m_cnt == 0);
      acc = cif.cmd_valid && m_ready;
      for (int i = 0; i < 2; i++) begin
        m_pwm[i] = enable && (m_cnt < m_pulse[i]);
        if (fs) begin
          d = m_tgt[i] - m_pos[i];
          if (d > STP)       m_pos[i] = m_pos[i] + STP;
          else if (d < -STP) m_pos[i] = m_pos[i] - STP;
          else               m_pos[i] = m_tgt[i];
          m_pulse[i] = to_pulse(m_pos[i]);
        end
        if (acc) m_tgt[i] = (cmdv[i] > MAXA) ? MAXA : cmdv[i];
      end
      m_ready = 1;
      if (enable) m_cnt = (m_cnt + 1) % FT;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    logic [20:0] act, expv;
    @(negedge clk);
    cycle++;
    if (arrived === 1'b1) arr_seen++;
    if (chk_on) begin
      act  = {pos_base, pos_arm, busy, arrived, cif.cmd_ready, pwm_base, pwm_arm};
      expv = {8'(m_pos[0]), 8'(m_pos[1]), m_busy, m_arr, m_ready, m_pwm[0], m_pwm[1]};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL model_cmp cycle %0d: got %h expected %h", cycle, act, expv);
      end
    end
  end

  task automatic check(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_cnt(int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != v && n < 5000);
    if (n >= 5000) check("wait_cnt_timeout", n, 0);
  endtask

  // Starts at a negedge with m_cnt==1; sums PWM high cycles over one full frame.
  task automatic measure(output int hb, output int ha);
    int n = 0;
    hb = 0; ha = 0;
    do begin
      hb += int'(pwm_base);
      ha += int'(pwm_arm);
      @(negedge clk);
      n++;
    end while (m_cnt != 1 && n < 5000);
    if (n >= 5000) check("measure_timeout", n, 0);
  endtask

  task automatic send_cmd(int b, int a);
    cif.cmd_valid = 1'b1;
    cif.cmd_base  = 8'(b);
    cif.cmd_arm   = 8'(a);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hb, ha, n, a0;
    bit dropped;
    int exp_b[5];
    int exp_a[5];
    exp_b = '{92, 94, 96, 98, 100};
    exp_a = '{88, 86, 85, 85, 85};
    cif.cmd_valid = 1'b0;
    cif.cmd_base  = '0;
    cif.cmd_arm   = '0;

    // Reset state
    @(negedge clk);
    chk_on = 1'b1;
    check("rst_pos_base", int'(pos_base), 90);
    check("rst_pos_arm", int'(pos_arm), 90);
    check("rst_ready", int'(cif.cmd_ready), 0);
    check("rst_pwm", int'(pwm_base) + int'(pwm_arm), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", int'(cif.cmd_ready), 1);

    // Idle frames at home
    for (int f = 0; f < 2; f++) begin
      measure(hb, ha);
      check("idle_hi_base", hb, 190);
      check("idle_hi_arm", ha, 190);
    end
    check("idle_busy", int'(busy), 0);
    check("idle_arrived", arr_seen, 0);

    // Slew to base=100, arm=85
    send_cmd(100, 85);
    for (int k = 0; k < 5; k++) begin
      wait_cnt(1);
      check("slew_base", int'(pos_base), exp_b[k]);
      check("slew_arm", int'(pos_arm), exp_a[k]);
      if (k < 4) check("slew_busy", int'(busy), 1);
    end
    @(negedge clk);
    check("arrive_pulse", int'(arrived), 1);
    check("arrive_busy", int'(busy), 0);
    @(negedge clk);
    check("arrive_one_cycle", int'(arrived), 0);
    check("arrive_count", arr_seen, 1);
    wait_cnt(1);
    measure(hb, ha);
    check("hi_base_100", hb, 200);
    check("hi_arm_85", ha, 185);

    // Clamp to MAX_ANGLE
    send_cmd(250, 85);
    repeat (45) wait_cnt(1);
    check("clamp_pos", int'(pos_base), 180);
    measure(hb, ha);
    check("clamp_hi_base", hb, 280);

    // Command accepted on the frame-start cycle, then reversal mid-slew
    wait_cnt(0);
    send_cmd(170, 85);
    check("fs_cmd_no_motion", int'(pos_base), 180);
    wait_cnt(1);
    check("fs_cmd_step1", int'(pos_base), 178);
    wait_cnt(1);
    check("fs_cmd_step2", int'(pos_base), 176);
    send_cmd(180, 85);
    wait_cnt(1);
    check("reverse_step", int'(pos_base), 178);
    wait_cnt(1);
    check("reverse_done", int'(pos_base), 180);

    // Enable gap of 1000 cycles mid-pulse; command accepted while disabled
    hb = 0; n = 0; dropped = 1'b0;
    do begin
      hb += int'(pwm_base);
      if (m_cnt == 150 && !dropped) begin
        dropped = 1'b1;
        enable = 1'b0;
        cif.cmd_valid = 1'b1;
        cif.cmd_base  = 8'd90;
        cif.cmd_arm   = 8'd85;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          cif.cmd_valid = 1'b0;
          hb += int'(pwm_base);
          if (i == 0) check("gap_pwm_low", int'(pwm_base), 0);
        end
        check("gap_pos_frozen", int'(pos_base), 180);
        enable = 1'b1;
      end
      @(negedge clk);
      n++;
    end while (m_cnt != 1 && n < 5000);
    check("gap_frame_hi", hb, 280);
    check("gap_cmd_took", int'(pos_base), 178);

    // Reset mid-slew at pos_base=120
    n = 0;
    while (m_pos[0] != 120 && n < 100) begin
      wait_cnt(1);
      n++;
    end
    check("pre_reset_pos", int'(pos_base), 120);
    wait_cnt(60);
    rst = 1'b1;
    a0 = arr_seen;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_pos_base", int'(pos_base), 90);
    check("mid_rst_pos_arm", int'(pos_arm), 90);
    check("mid_rst_pwm", int'(pwm_base) + int'(pwm_arm), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(cif.cmd_ready), 0);
    @(negedge clk);
    check("mid_rst_ready_back", int'(cif.cmd_ready), 1);
    measure(hb, ha);
    check("post_rst_hi_base", hb, 190);
    check("post_rst_hi_arm", ha, 190);
    check("post_rst_no_arrive", arr_seen, a0);
    check("post_rst_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/panel_servo_driver.md
Name: panel_servo_driver

Overview:
- Panel-side end of the tracker command path.
- Accepts base/arm target angles (0..180 deg, 8-bit) from the tracking controller through a valid/ready handshake.
- Slew-limits each axis toward its target, once per servo frame.
- Generates the two hobby-servo PWM signals and reports when both axes have reached their targets.

Parameters:
- FRAME_TICKS, 20000, clock ticks per PWM frame (20 ms at 1 MHz).
- MIN_PULSE_TICKS, 1000, pulse width for angle 0.
- MAX_PULSE_TICKS, 2000, pulse width for angle MAX_ANGLE.
- MAX_ANGLE, 180, largest legal angle; larger commands are clamped to it.
- STEP, 2, maximum position change per axis per frame, in degrees.
- HOME_ANGLE, 90, position and target for both axes after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  1 = run; 0 = freeze frame counter, positions and PWM.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_base  in  8  base target angle.
- cmd_arm  in  8  arm target angle.
- pwm_base  out  1  base servo PWM.
- pwm_arm  out  1  arm servo PWM.
- pos_base  out  8  current commanded base position.
- pos_arm  out  8  current commanded arm position.
- busy  out  1  a position differs from its target.
- arrived  out  1  one-cycle pulse when busy falls.

Behaviour:
- Reset, sampled on posedge clk with rst=1, sets:
  - frame_cnt=0;
  - pos_*=HOME_ANGLE and tgt_*=HOME_ANGLE;
  - pwm_*=0, busy=0, arrived=0, cmd_ready=0;
  - pulse_* (latched pulse width) = width of HOME_ANGLE.
- A reset mid-slew abandons the current targets.
- cmd_ready is 1 in every cycle after the first post-reset cycle; it does not depend on enable.
- Command acceptance:
  - A command is accepted on a cycle where cmd_valid && cmd_ready.
  - tgt_base = min(cmd_base, MAX_ANGLE) and tgt_arm = min(cmd_arm, MAX_ANGLE), registered at that edge.
  - A new command overwrites targets at any time, including mid-slew.
  - Targets equal to the current positions cause no motion and no arrived pulse.
- Frame counter: counts 0..FRAME_TICKS-1 and wraps; it advances only while enable=1.
- Frame start is the cycle with frame_cnt==0 and enable=1. At that edge, per axis:
  - d = tgt - pos;
  - if |d| <= STEP then pos = tgt, else pos moves STEP toward tgt;
  - pulse = MIN_PULSE_TICKS + (new_pos*(MAX_PULSE_TICKS-MIN_PULSE_TICKS))/MAX_ANGLE.
- Width rules for the frame-start update:
  - d is computed signed, 9 bits.
  - The pulse product uses an intermediate of at least 8 + clog2(span) bits; division truncates.
- Target sampled at frame start:
  - The slew step uses the tgt value held before the frame-start edge.
  - A command accepted on the frame-start cycle itself takes effect at the next frame start.
- PWM: pwm_* = 1 in the cycle after each count value frame_cnt < pulse_*, else 0.
  - Output is registered; latency is 1 cycle from the counter.
  - Exactly pulse_* high cycles per frame.
- Status:
  - busy = (pos_base != tgt_base) || (pos_arm != tgt_arm), registered.
  - arrived = 1 for one cycle when busy transitions 1->0.
- enable=0:
  - pwm_* forced to 0 on the next edge;
  - frame_cnt, pos_* and pulse_* hold;
  - commands are still accepted.
  - On re-enable, counting resumes from the held frame_cnt.
- Angle 0 always gives a pulse of at least MIN_PULSE_TICKS >= 1.
- MAX_ANGLE gives exactly MAX_PULSE_TICKS, which must be < FRAME_TICKS (elaboration check).

Decomposition:
- Shared package servo_pkg holds:
  - angle_t (8-bit typedef);
  - ANGLE_MAX=180 and HOME_ANGLE=90;
  - the function angle_to_pulse().
- One sub-module servo_axis, instantiated twice. It owns tgt, pos, slew, pulse width and PWM comparison for one axis.
- The top level owns the shared frame counter, the handshake, and busy/arrived.

Test Plan:
- Parameters for all scenarios: FRAME_TICKS=400, MIN=100, MAX=280, STEP=2. With these, pulse = 100 + angle.
- Reset, then idle 2 frames -> pos_*=90, every frame has exactly 190 high cycles on both PWMs, busy=0, arrived never pulses.
- Command base=100, arm=85 -> base slews 92,94,96,98,100 over 5 frame starts. Arm slews 88,86,85 (last step 1). busy stays 1 until frame 5, then arrived pulses once; the base pulse is 200 cycles thereafter.
- Command base=250 -> clamped to 180; after 45 frames pos_base=180 and the pulse is 280 cycles.
- Command accepted exactly on the frame_cnt==0 cycle -> no motion that frame; first step occurs one frame later. A second command mid-slew reverses direction at the next frame start.
- Drop enable for 1000 cycles mid-pulse -> PWM low within 1 cycle, pos and frame_cnt frozen; on resume the remaining high cycles complete, so the frame still totals pulse_* high cycles.
- Assert rst mid-slew (pos_base=120) -> next cycle pos_*=90, tgt_*=90, pwm_*=0, busy=0, no arrived pulse, cmd_ready=0 for one cycle.
